// File: rtl/cpu_axi_pkg.sv
// cpu_axi_pkg: shared types and constants for the CPU-to-AXI arbiter.
package cpu_axi_pkg;
   typedef enum logic [2:0] {IDLE, AR, R, W, B} state_e;
   localparam logic [1:0] SIZE_BYTE = 2'd0;
   localparam logic [1:0] SIZE_HALF = 2'd1;
   localparam logic [1:0] SIZE_WORD = 2'd2;
   localparam logic [3:0] ID_INST_DEF = 4'd0;
   localparam logic [3:0] ID_DATA_DEF = 4'd1;
endpackage

// File: rtl/cpu_axi_arbiter_if.sv
// cpu_axi_arbiter_if: AXI3 master-side channel signals used by the arbiter.
interface cpu_axi_arbiter_if;
   logic [3:0]  arid;
   logic [31:0] araddr;
   logic [2:0]  arsize;
   logic        arvalid;
   logic        arready;
   logic [31:0] rdata;
   logic        rvalid;
   logic        rready;
   logic [3:0]  awid;
   logic [31:0] awaddr;
   logic [2:0]  awsize;
   logic        awvalid;
   logic        awready;
   logic [3:0]  wid;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wvalid;
   logic        wready;
   logic        bvalid;
   logic        bready;
   modport master (
      output arid, araddr, arsize, arvalid, input arready,
      input rdata, rvalid, output rready,
      output awid, awaddr, awsize, awvalid, input awready,
      output wid, wdata, wstrb, wvalid, input wready,
      input bvalid, output bready
   );
   modport slave (
      input arid, araddr, arsize, arvalid, output arready,
      output rdata, rvalid, input rready,
      input awid, awaddr, awsize, awvalid, output awready,
      input wid, wdata, wstrb, wvalid, output wready,
      output bvalid, input bready
   );
endinterface

// File: rtl/axi_wstrb_gen.sv
// axi_wstrb_gen: byte-lane write strobes from access size and address offset.
module axi_wstrb_gen
   import cpu_axi_pkg::*;
(
   input  logic [1:0] size,
   input  logic [1:0] offset,
   output logic [3:0] wstrb
);
   always_comb wstrb = (size == SIZE_BYTE) ? 4'b0001 << offset :
                       (size == SIZE_HALF) ? 4'b0011 << {offset[1], 1'b0} : 4'b1111;
endmodule

// File: rtl/cpu_axi_arbiter.sv
// cpu_axi_arbiter: merges CPU inst/data SRAM-like ports onto one AXI3 master,
// one outstanding transaction, data side has priority.
module cpu_axi_arbiter
   import cpu_axi_pkg::*;
#(
   parameter logic [3:0] ID_INST = ID_INST_DEF,
   parameter logic [3:0] ID_DATA = ID_DATA_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        inst_req,
   input  logic [1:0]  inst_size,
   input  logic [31:0] inst_addr,
   output logic        inst_addr_ok,
   output logic        inst_data_ok,
   output logic [31:0] inst_rdata,
   input  logic        data_req,
   input  logic        data_wr,
   input  logic [1:0]  data_size,
   input  logic [31:0] data_addr,
   input  logic [31:0] data_wdata,
   output logic        data_addr_ok,
   output logic        data_data_ok,
   output logic [31:0] data_rdata,
   cpu_axi_arbiter_if.master axi
);
   state_e      state_q, state_d;
   logic        owner_q, owner_d;
   logic [1:0]  size_q, size_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic        aw_done_q, aw_done_d;
   logic        w_done_q, w_done_d;
   logic        arvalid_q, arvalid_d;
   logic        awvalid_q, awvalid_d;
   logic        wvalid_q, wvalid_d;
   logic        rready_q, rready_d;
   logic        bready_q, bready_d;
   logic        idle;
   assign idle = state_q == IDLE;
   always_comb begin
      state_d   = state_q;
      owner_d   = owner_q;
      size_d    = size_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      aw_done_d = aw_done_q;
      w_done_d  = w_done_q;
      case (state_q)
         IDLE: if (data_req || inst_req) begin
            owner_d   = data_req;
            size_d    = data_req ? data_size : inst_size;
            addr_d    = data_req ? data_addr : inst_addr;
            wdata_d   = data_wdata;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
            state_d   = (data_req && data_wr) ? W : AR;
         end
         AR: state_d = axi.arready ? R : AR;
         R:  state_d = axi.rvalid ? IDLE : R;
         W: begin
            aw_done_d = aw_done_q | axi.awready;
            w_done_d  = w_done_q | axi.wready;
            state_d   = (aw_done_d && w_done_d) ? B : W;
         end
         B:  state_d = axi.bvalid ? IDLE : B;
         default: state_d = IDLE;
      endcase
      // Handshake outputs are decoded from the next state so they register cleanly.
      arvalid_d = state_d == AR;
      rready_d  = state_d == R;
      awvalid_d = (state_d == W) && !aw_done_d;
      wvalid_d  = (state_d == W) && !w_done_d;
      bready_d  = state_d == B;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         owner_q   <= 1'b0;
         size_q    <= 2'b0;
         addr_q    <= 32'b0;
         wdata_q   <= 32'b0;
         aw_done_q <= 1'b0;
         w_done_q  <= 1'b0;
         arvalid_q <= 1'b0;
         awvalid_q <= 1'b0;
         wvalid_q  <= 1'b0;
         rready_q  <= 1'b0;
         bready_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         owner_q   <= owner_d;
         size_q    <= size_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         aw_done_q <= aw_done_d;
         w_done_q  <= w_done_d;
         arvalid_q <= arvalid_d;
         awvalid_q <= awvalid_d;
         wvalid_q  <= wvalid_d;
         rready_q  <= rready_d;
         bready_q  <= bready_d;
      end
   end
   assign data_addr_ok = idle && data_req;
   assign inst_addr_ok = idle && !data_req && inst_req;
   assign inst_data_ok = (state_q == R) && axi.rvalid && !owner_q;
   assign data_data_ok = ((state_q == R) && axi.rvalid && owner_q) || ((state_q == B) && axi.bvalid);
   assign inst_rdata   = axi.rdata;
   assign data_rdata   = axi.rdata;
   assign axi.arid     = owner_q ? ID_DATA : ID_INST;
   assign axi.araddr   = addr_q;
   assign axi.arsize   = {1'b0, size_q};
   assign axi.arvalid  = arvalid_q;
   assign axi.rready   = rready_q;
   assign axi.awid     = ID_DATA;
   assign axi.awaddr   = addr_q;
   assign axi.awsize   = {1'b0, size_q};
   assign axi.awvalid  = awvalid_q;
   assign axi.wid      = ID_DATA;
   assign axi.wdata    = wdata_q;
   assign axi.wvalid   = wvalid_q;
   assign axi.bready   = bready_q;
   axi_wstrb_gen u_wstrb (
      .size   (size_q),
      .offset (addr_q[1:0]),
      .wstrb  (axi.wstrb)
   );
endmodule
